// File: rtl/rtc_bcd_field_bank_if.sv
// Bus-side signal bundle for the RTC BCD field bank.
// The multiplexed address/data bus itself stays a plain inout port on the bank.
interface rtc_bcd_field_bank_if #(
    parameter int unsigned NUM_FIELDS = 9
);
    logic [7:0]              ADRESS;
    logic                    BEnv_Adress;
    logic                    BEnv_Data;
    logic                    BRes_Data;
    logic [7:0]              Puntero;
    logic                    UP;
    logic                    DOWN;
    logic [8*NUM_FIELDS-1:0] fields_o;
    logic [NUM_FIELDS-1:0]   dirty_o;
    logic                    wb_req;
    logic                    timer_done;
    logic                    cap_err;

    modport master (
        output ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, Puntero, UP, DOWN,
        input  fields_o, dirty_o, wb_req, timer_done, cap_err
    );

    modport slave (
        input  ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, Puntero, UP, DOWN,
        output fields_o, dirty_o, wb_req, timer_done, cap_err
    );
endinterface

// File: rtl/rtc_bcd_field_bank.sv
// Bank of packed-BCD time/date/timer fields sitting between the RTC multiplexed bus and
// the display. Handles bus capture, manual up/down editing, dirty tracking and write-back.
module rtc_bcd_field_bank #(
    parameter int unsigned                 NUM_FIELDS = 9,
    parameter logic [8*NUM_FIELDS-1:0]     ADDR_MAP   = 72'h41_42_43_21_22_23_24_25_26,
    parameter logic [8*NUM_FIELDS-1:0]     MIN_MAP    = 72'h00_00_00_00_00_00_01_01_00,
    parameter logic [8*NUM_FIELDS-1:0]     MAX_MAP    = 72'h59_59_23_59_59_23_31_12_99,
    parameter logic [NUM_FIELDS-1:0]       INV_MASK   = 9'b111000000,
    parameter logic [7:0]                  IDLE_DATA  = 8'hFF
) (
    input  logic                 CLK,
    input  logic                 RST,
    rtc_bcd_field_bank_if.slave  bus,
    inout  wire  [7:0]           Multiplex
);

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Wrapping BCD increment within [mn, mx].
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v == mx) return mn;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Wrapping BCD decrement within [mn, mx].
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v == mn) return mx;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Digit-wise BCD a - b; only meaningful when a >= b.
    function automatic logic [7:0] bcd_sub(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] u;
        logic       borrow;
        if (a[3:0] >= b[3:0]) begin
            u      = a[3:0] - b[3:0];
            borrow = 1'b0;
        end else begin
            u      = a[3:0] + 4'd10 - b[3:0];
            borrow = 1'b1;
        end
        return {a[7:4] - b[7:4] - {3'd0, borrow}, u};
    endfunction

    function automatic logic has_dup(input logic [8*NUM_FIELDS-1:0] m);
        for (int i = 0; i < NUM_FIELDS; i++) begin
            for (int j = i + 1; j < NUM_FIELDS; j++) begin
                if (m[8*i +: 8] == m[8*j +: 8]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    localparam logic ADDR_DUP = has_dup(ADDR_MAP);

    logic [8*NUM_FIELDS-1:0] field_q, field_d;
    logic [NUM_FIELDS-1:0]   dirty_q, dirty_d;
    logic [7:0]              data_q, data_d;
    logic                    up_q, down_q, up_p, down_p;
    logic                    benv_data_q;
    logic                    cap_err_q, cap_err_d;
    logic                    timer_done_w;
    logic                    drive_en;
    logic [7:0]              drive_val;

    // Timer is done once every complemented field sits at its maximum.
    always_comb begin
        timer_done_w = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (INV_MASK[i] && (field_q[8*i +: 8] != MAX_MAP[8*i +: 8])) timer_done_w = 1'b0;
        end
    end

    // Write-back data for the addressed field, in bus encoding.
    always_comb begin
        data_d = IDLE_DATA;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (ADDR_MAP[8*i +: 8] == bus.ADRESS) begin
                data_d = INV_MASK[i] ? bcd_sub(MAX_MAP[8*i +: 8], field_q[8*i +: 8])
                                     : field_q[8*i +: 8];
            end
        end
    end

    // Next field/dirty state: capture, then write-back clear, then edit (edit wins).
    always_comb begin
        logic [7:0] mn, mx, cur, cand;
        logic       cand_ok, edit_hit, cap_hit;
        field_d   = field_q;
        dirty_d   = dirty_q;
        cap_err_d = 1'b0;
        mn        = '0;
        mx        = '0;
        cur       = '0;
        cand      = '0;
        cand_ok   = 1'b0;
        edit_hit  = 1'b0;
        cap_hit   = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            mn       = MIN_MAP[8*i +: 8];
            mx       = MAX_MAP[8*i +: 8];
            cur      = field_q[8*i +: 8];
            edit_hit = (ADDR_MAP[8*i +: 8] == bus.Puntero) && (up_p ^ down_p);
            cap_hit  = bus.BRes_Data && (ADDR_MAP[8*i +: 8] == bus.ADRESS) &&
                       !dirty_q[i] && !edit_hit;
            if (INV_MASK[i]) begin
                cand    = bcd_sub(mx, Multiplex);
                cand_ok = bcd_valid(Multiplex) && (Multiplex <= mx) && (cand >= mn);
            end else begin
                cand    = Multiplex;
                cand_ok = bcd_valid(Multiplex) && (Multiplex >= mn) && (Multiplex <= mx);
            end
            if (cap_hit) begin
                if (INV_MASK[i] && timer_done_w) field_d[8*i +: 8] = mn;
                else if (cand_ok)                field_d[8*i +: 8] = cand;
                else                             cap_err_d = 1'b1;
            end
            if (benv_data_q && !bus.BEnv_Data && (ADDR_MAP[8*i +: 8] == bus.ADRESS)) begin
                dirty_d[i] = 1'b0;
            end
            if (edit_hit) begin
                field_d[8*i +: 8] = up_p ? bcd_inc(cur, mn, mx) : bcd_dec(cur, mn, mx);
                dirty_d[i]        = 1'b1;
            end
        end
    end

    // State registers, edge detectors and registered bus data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            field_q     <= MIN_MAP;
            dirty_q     <= '0;
            data_q      <= IDLE_DATA;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            up_p        <= 1'b0;
            down_p      <= 1'b0;
            benv_data_q <= 1'b0;
            cap_err_q   <= 1'b0;
        end else begin
            field_q     <= field_d;
            dirty_q     <= dirty_d;
            data_q      <= data_d;
            up_q        <= bus.UP;
            down_q      <= bus.DOWN;
            up_p        <= bus.UP & ~up_q;
            down_p      <= bus.DOWN & ~down_q;
            benv_data_q <= bus.BEnv_Data;
            cap_err_q   <= cap_err_d;
        end
    end

    // Two fields on one address would both answer the same bus cycle.
    always_ff @(posedge CLK) begin
        assert (!ADDR_DUP) else $error("rtc_bcd_field_bank: duplicate ADDR_MAP entry");
    end

    // Address phase has priority over data phase; reset releases the bus at once.
    always_comb begin
        drive_en  = !RST && (bus.BEnv_Adress || bus.BEnv_Data);
        drive_val = bus.BEnv_Adress ? bus.ADRESS : data_q;
    end

    assign Multiplex      = drive_en ? drive_val : 8'hzz;
    assign bus.fields_o   = field_q;
    assign bus.dirty_o    = dirty_q;
    assign bus.wb_req     = |dirty_q;
    assign bus.timer_done = timer_done_w;
    assign bus.cap_err    = cap_err_q;

endmodule

// File: tb/tb_rtc_bcd_field_bank.sv
// Scoreboard bench for rtc_bcd_field_bank: a decimal reference model predicts each cycle's
// outputs into a queue, and a monitor on the falling edge pops and compares.
module tb_rtc_bcd_field_bank;
    localparam int N = 9;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    rtc_bcd_field_bank_if #(.NUM_FIELDS(N)) bus_if ();
    wire  [7:0] mux;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = 8'h00;
    assign mux = tb_drv ? tb_val : 8'hzz;

    rtc_bcd_field_bank dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus_if),
        .Multiplex (mux)
    );

    // Reference tables, field 0 first.
    int m_addr[N] = '{'h26, 'h25, 'h24, 'h23, 'h22, 'h21, 'h43, 'h42, 'h41};
    int m_min[N]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    int m_max[N]  = '{99, 12, 31, 23, 59, 59, 23, 59, 59};
    bit m_inv[N]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

    // Model state, values held as plain decimal integers.
    int         val[N];
    bit         drt[N];
    bit         upq, dnq, upp, dnp, bdq, ce;
    logic [7:0] data_m;

    typedef struct packed {
        logic [71:0] f;
        logic [8:0]  d;
        logic        wb;
        logic        td;
        logic        ce;
        logic        chk;
        logic [7:0]  bus;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit model_td();
        bit td = 1'b1;
        for (int i = 0; i < N; i++) if (m_inv[i] && val[i] != m_max[i]) td = 1'b0;
        return td;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            val[i] = m_min[i];
            drt[i] = 1'b0;
        end
        {upq, dnq, upp, dnp, bdq, ce} = '0;
        data_m = 8'hFF;
    endtask

    // One rising clock edge of the reference behaviour.
    task automatic model_edge();
        int nval[N];
        bit ndrt[N];
        bit td, edit;
        int b, c;
        td   = model_td();
        nval = val;
        ndrt = drt;
        ce   = 1'b0;
        data_m = 8'hFF;
        for (int i = 0; i < N; i++) begin
            if (m_addr[i] == int'(bus_if.ADRESS))
                data_m = to_bcd(m_inv[i] ? m_max[i] - val[i] : val[i]);
        end
        for (int i = 0; i < N; i++) begin
            edit = (m_addr[i] == int'(bus_if.Puntero)) && (upp != dnp);
            if (bus_if.BRes_Data && m_addr[i] == int'(bus_if.ADRESS) && !drt[i] && !edit) begin
                if (m_inv[i] && td) begin
                    nval[i] = m_min[i];
                end else begin
                    b = from_bcd(tb_val);
                    c = m_inv[i] ? m_max[i] - b : b;
                    if (is_bcd(tb_val) && c >= m_min[i] && c <= m_max[i]) nval[i] = c;
                    else ce = 1'b1;
                end
            end
            if (bdq && !bus_if.BEnv_Data && m_addr[i] == int'(bus_if.ADRESS)) ndrt[i] = 1'b0;
            if (edit) begin
                if (upp) nval[i] = (val[i] == m_max[i]) ? m_min[i] : val[i] + 1;
                else     nval[i] = (val[i] == m_min[i]) ? m_max[i] : val[i] - 1;
                ndrt[i] = 1'b1;
            end
        end
        val = nval;
        drt = ndrt;
        upp = bus_if.UP && !upq;
        upq = bus_if.UP;
        dnp = bus_if.DOWN && !dnq;
        dnq = bus_if.DOWN;
        bdq = bus_if.BEnv_Data;
    endtask

    task automatic push_exp();
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.f[8*i +: 8] = to_bcd(val[i]);
            e.d[i]        = drt[i];
        end
        e.wb  = |e.d;
        e.td  = model_td();
        e.ce  = ce;
        e.chk = !RST && (bus_if.BEnv_Adress || bus_if.BEnv_Data);
        e.bus = bus_if.BEnv_Adress ? bus_if.ADRESS : data_m;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("fields", 72'(bus_if.fields_o), e.f);
                chk("dirty", 72'(bus_if.dirty_o), 72'(e.d));
                chk("wb_req", 72'(bus_if.wb_req), 72'(e.wb));
                chk("timer_done", 72'(bus_if.timer_done), 72'(e.td));
                chk("cap_err", 72'(bus_if.cap_err), 72'(e.ce));
                if (e.chk) chk("bus", 72'(mux), 72'(e.bus));
            end
        end
    end

    task automatic drive(input logic [7:0] adr, input logic ba, input logic bd, input logic br,
                         input logic [7:0] bv, input logic [7:0] pt, input logic u,
                         input logic d);
        bus_if.ADRESS      = adr;
        bus_if.BEnv_Adress = ba;
        bus_if.BEnv_Data   = bd;
        bus_if.BRes_Data   = br;
        bus_if.Puntero     = pt;
        bus_if.UP          = u;
        bus_if.DOWN        = d;
        tb_val             = bv;
        tb_drv             = br && !ba && !bd;
    endtask

    task automatic cyc(input logic [7:0] adr, input logic ba, input logic bd, input logic br,
                       input logic [7:0] bv, input logic [7:0] pt, input logic u,
                       input logic d);
        drive(adr, ba, bd, br, bv, pt, u, d);
        @(posedge CLK);
        #1;
        model_edge();
        push_exp();
        @(negedge CLK);
        #1;
    endtask

    // Asynchronous reset, checked while still asserted.
    task automatic do_reset();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        RST = 1'b1;
        #1;
        model_reset();
        push_exp();
        @(negedge CLK);
        #1;
        RST = 1'b0;
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 5) == 0) return 8'($urandom);
        return 8'(m_addr[$urandom_range(0, N - 1)]);
    endfunction

    initial begin
        logic [7:0] adr, pt, bv;
        logic       u, d;
        int         mode;

        do_reset();
        // Plain capture into minutes-like field at 22h.
        cyc(8'h22, 0, 0, 1, 8'h37, 8'h00, 0, 0);
        // Hour edits: DOWN wraps 00 -> 23, UP wraps 23 -> 00.
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 0, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 0, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 0, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 1, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 1, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h23, 0, 0);
        // Day 01 -> 31, then a capture while dirty is discarded.
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h24, 0, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h24, 0, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h24, 0, 0);
        cyc(8'h24, 0, 0, 1, 8'h15, 8'h00, 0, 0);
        // Write-back of day, dirty clears on BEnv_Data fall.
        cyc(8'h24, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        cyc(8'h24, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        cyc(8'h24, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Timer hours in complemented form.
        cyc(8'h43, 0, 0, 1, 8'h20, 8'h00, 0, 0);
        cyc(8'h43, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        cyc(8'h43, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        cyc(8'h43, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Drive all timer fields to MAX, then the next timer capture loads MIN.
        cyc(8'h41, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        cyc(8'h42, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        cyc(8'h43, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        cyc(8'h43, 0, 0, 1, 8'h05, 8'h00, 0, 0);
        // Rejected captures: invalid nibble and out of range.
        cyc(8'h21, 0, 0, 1, 8'h7A, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        cyc(8'h21, 0, 0, 1, 8'h65, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Address phase wins over data phase.
        cyc(8'h25, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        // Edit and capture on the same field in one cycle: edit wins.
        cyc(8'h25, 0, 0, 0, 8'h00, 8'h25, 1, 0);
        cyc(8'h25, 0, 0, 1, 8'h05, 8'h25, 1, 0);
        cyc(8'h25, 0, 0, 0, 8'h00, 8'h25, 0, 0);
        // Simultaneous UP and DOWN pulses do nothing.
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h26, 1, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h26, 1, 1);
        cyc(8'h00, 0, 0, 0, 8'h00, 8'h26, 0, 0);
        // BEnv_Data falls on the same edge as an edit: dirty stays set.
        cyc(8'h26, 0, 1, 0, 8'h00, 8'h26, 1, 0);
        cyc(8'h26, 0, 0, 0, 8'h00, 8'h26, 1, 0);
        cyc(8'h26, 0, 0, 0, 8'h00, 8'h26, 0, 0);
        // Reset in the middle of activity discards pending edits.
        do_reset();

        for (int k = 0; k < 1500; k++) begin
            mode = int'($urandom_range(0, 5));
            adr  = pick_addr();
            pt   = pick_addr();
            u    = ($urandom_range(0, 2) == 0);
            d    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) bv = to_bcd(int'($urandom_range(0, 99)));
            else                           bv = 8'($urandom);
            case (mode)
                1, 2:    cyc(adr, 0, 0, 1, bv, pt, u, d);
                3:       cyc(adr, 0, 1, 0, bv, pt, u, d);
                4:       cyc(adr, 1, 0, 0, bv, pt, u, d);
                5:       cyc(adr, 1, 1, 0, bv, pt, u, d);
                default: cyc(adr, 0, 0, 0, bv, pt, u, d);
            endcase
            if (k % 500 == 499) do_reset();
        end

        repeat (3) @(negedge CLK);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
